// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the 2-to-4 decoder select.
// Grants are hold-limited and separated by one idle cycle.
module rr_select_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout_pulse,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             tp_q, tp_d;

    logic [1:0]       win;
    logic [1:0]       scan;
    logic             found;

    // First requester at or after the priority pointer.
    always_comb begin
        win   = ptr_q;
        scan  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan = ptr_q + 2'(i);
            if (!found && req[scan]) begin
                win   = scan;
                found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tp_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = win;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (done || !req[idx_q]) begin
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    state_d = IDLE;
                    tp_d    = 1'b1;
                end else begin
                    hold_d  = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tp_q    <= tp_d;
        end
    end

    assign grant_idx     = idx_q;
    assign grant_valid   = valid_q;
    assign timeout_pulse = tp_q;
    assign busy          = valid_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter.
// Expected values are hand-derived per step.
module tb_rr_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout_pulse;
    logic       busy;

    int errors = 0;
    int checks = 0;

    rr_select_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .done         (done),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .timeout_pulse(timeout_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic gv,
                           input logic [1:0] gi, input logic tp);
        chk({tag, ".gv"}, 8'(grant_valid), 8'(gv));
        chk({tag, ".gi"}, 8'(grant_idx), 8'(gi));
        chk({tag, ".tp"}, 8'(timeout_pulse), 8'(tp));
        chk({tag, ".busy"}, 8'(busy), 8'(gv));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", 1'b0, 2'd0, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk_out("rst_rel", 1'b1, 2'd0, 1'b0);

        // round robin 0,1,2,3,0 with one gap each
        for (int g = 1; g <= 4; g++) begin
            done = 1'b1;
            tick();
            chk_out("rr_gap", 1'b0, 2'(g - 1), 1'b0);
            done = 1'b0;
            tick();
            chk_out("rr_grant", 1'b1, 2'(g), 1'b0);
        end

        // pointer skip: reach ptr=2 via grant of 1
        done = 1'b1;
        tick();
        chk_out("ps_rel0", 1'b0, 2'd0, 1'b0);
        req  = 4'b0010;
        done = 1'b0;
        tick();
        chk_out("ps_g1", 1'b1, 2'd1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("ps_rel1", 1'b0, 2'd1, 1'b0);
        req  = 4'b0011;
        done = 1'b0;
        tick();
        chk_out("ps_wrap0", 1'b1, 2'd0, 1'b0);
        done = 1'b1;
        tick();
        chk_out("ps_rel2", 1'b0, 2'd0, 1'b0);
        req  = 4'b0010;
        done = 1'b0;
        tick();
        chk_out("ps_g1b", 1'b1, 2'd1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("ps_rel3", 1'b0, 2'd1, 1'b0);

        // timeout: requester 2 holds, no done
        req  = 4'b0100;
        done = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            chk_out("to_hold", 1'b1, 2'd2, 1'b0);
        end
        tick();
        chk_out("to_drop", 1'b0, 2'd2, 1'b1);
        tick();
        chk_out("to_regrant", 1'b1, 2'd2, 1'b0);

        // done on the last hold cycle beats timeout
        for (int c = 0; c < 15; c++) begin
            tick();
            chk_out("sim_hold", 1'b1, 2'd2, 1'b0);
        end
        done = 1'b1;
        tick();
        chk_out("sim_rel", 1'b0, 2'd2, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("sim_idle", 1'b0, 2'd2, 1'b0);

        // done while idle is ignored
        tick();
        chk_out("idle_done", 1'b0, 2'd2, 1'b0);

        // owner 3 drops its request
        done = 1'b0;
        req  = 4'b1000;
        tick();
        chk_out("own_g3", 1'b1, 2'd3, 1'b0);
        req = 4'b1001;
        tick();
        chk_out("own_keep", 1'b1, 2'd3, 1'b0);
        req = 4'b0001;
        tick();
        chk_out("own_drop", 1'b0, 2'd3, 1'b0);
        req = 4'b1111;
        tick();
        chk_out("own_ptr0", 1'b1, 2'd0, 1'b0);

        // reset mid-grant clears pointer
        done = 1'b1;
        tick();
        chk_out("mr_rel", 1'b0, 2'd0, 1'b0);
        done = 1'b0;
        tick();
        chk_out("mr_g1", 1'b1, 2'd1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_out("mr_reset", 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("mr_ptr0", 1'b1, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Sequential front end for the 2-to-4 decoder stage.
- Arbitrates among 4 requesters with rotating (round-robin) priority.
- Drives the decoder's 2-bit select input with the winning index, plus a valid qualifier.
- Bounds each grant with a hold timeout so no requester can starve the others.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may stay asserted before forced release; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  4  request vector; bit i = requester i wants the decoded line i.
- done  input  1  current owner releases its grant; ignored when no grant is active.
- grant_idx  output  2  registered binary index of the granted requester; feeds the decoder select.
- grant_valid  output  1  registered; high while grant_idx is a live grant.
- timeout_pulse  output  1  registered one-cycle pulse when a grant is force-released by the hold limit.
- busy  output  1  equal to grant_valid; kept as a separate port for status logic.

Behaviour:
- Reset (rst_n=0 at a clk edge): grant_idx=0, grant_valid=0, timeout_pulse=0, busy=0, priority pointer ptr=0, hold_cnt=0, state=IDLE. Reset overrides every other event, including mid-grant; state is cleared at that edge.
- State machine has two states: IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; outputs are unchanged except grant_valid=0.
  - Otherwise select the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (indices mod 4).
  - At the next edge: grant_idx=winner, grant_valid=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled at edge k produces grant_valid high from edge k onward, i.e. visible in cycle k+1.
- GRANT, on each edge, evaluated in priority order:
  - 1) Release if done==1 or req[grant_idx]==0. Result: grant_valid=0, ptr=grant_idx+1 (mod 4), go to IDLE, timeout_pulse=0.
  - 2) Timeout if hold_cnt==MAX_HOLD-1. Result: same as release, plus timeout_pulse=1 for exactly one cycle.
  - 3) Otherwise hold_cnt increments and grant_idx/grant_valid are held.
- A grant is therefore high for at most MAX_HOLD cycles.
- done and timeout in the same cycle: done wins; no timeout_pulse.
- After any release there is exactly one IDLE cycle with grant_valid=0 before the next grant. This guarantees a decoder output gap between owners.
- grant_idx keeps its last value while grant_valid=0. Downstream logic must gate the decoder with grant_valid.
- req changes on non-owner bits during GRANT are ignored until the next IDLE.
- done asserted in IDLE is ignored.
- timeout_pulse is 0 in every cycle except the one following a forced release.
- ptr wraps 3 -> 0.
- hold_cnt never exceeds MAX_HOLD-1 and is cleared on entry to GRANT.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 -> grant_valid=0, grant_idx=0, timeout_pulse=0 throughout; release rst_n -> grant_idx=0, grant_valid=1 one cycle later.
- Round-robin: req=4'b1111 held, pulse done 1 cycle after each grant -> grant_idx sequence 0,1,2,3,0 with exactly one grant_valid=0 cycle between grants.
- Pointer skip: ptr=2 (after granting 1), req=4'b0011 -> grant_idx=0 (scan 2,3,0 hits 0); then req=4'b0010 -> grant_idx=1.
- Timeout: MAX_HOLD=16, req=4'b0100 held, done=0 -> grant_valid high for exactly 16 cycles, timeout_pulse=1 on the cycle it drops, then grant_idx=2 regranted after one idle cycle.
- Simultaneous: assert done exactly on the hold_cnt==MAX_HOLD-1 cycle -> grant released, timeout_pulse stays 0.
- Owner drops / reset mid-grant: owner 3 deasserts req[3] with done=0 -> release next edge, ptr=0; separately, rst_n=0 mid-grant -> grant_valid=0 and ptr=0 at that edge.
